hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage RV32I core (IF, ID, EX, MEM, WB), placed beside the decode stage.
- Shadows the in-flight destination registers of the EX, MEM and WB stages.
- Detects RAW data hazards and control redirects from the ID-stage instruction.
- Drives stall, flush and bubble controls, plus forwarding selects, to the stage registers.

---
 rtl/hazard_pkg.sv | 45 ++++
 rtl/hazard_slot.sv | 21 ++
 rtl/hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for hazard_ctrl: forward selects, FSM states and the shadow-slot layout.
package hazard_pkg;

    localparam int SLOT_RD_W = 5;
    localparam int NUM_SLOTS = 3;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_LU_STALL = 2'd1,
        S_RAW_WAIT = 2'd2
    } state_t;

    // One in-flight instruction as seen by the hazard logic.
    typedef struct packed {
        logic                 v;
        logic [SLOT_RD_W-1:0] rd;
        logic                 wr;
        logic                 ld;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '0;

    function automatic logic slot_match(
        input slot_t                s,
        input logic [SLOT_RD_W-1:0] rs,
        input logic                 use_rs
    );
        return s.v & s.wr & (s.rd != '0) & (s.rd == rs) & use_rs;
    endfunction

    // The nearer producer holds the youngest value, so EX beats MEM.
    function automatic logic [1:0] fwd_pick(input logic hit_ex, input logic hit_mem);
        if (hit_ex)
            return FWD_EXMEM;
        else if (hit_mem)
            return FWD_MEMWB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_slot.sv
// One shadow pipeline stage: captures an instruction summary or a bubble every edge.
module hazard_slot
    import hazard_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  slot_t d,
    output slot_t q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q <= SLOT_BUBBLE;
        else if (load)
            q <= d;
        else
            q <= SLOT_BUBBLE;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller beside ID: shadows EX/MEM/WB destinations, drives stall/flush/forward.
// Build option: define FORWARDING_EN for operand forwarding with load-use-only stalls.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW = SLOT_RD_W,
    parameter int CNT_W  = 32
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_reg_write,
    input  logic              id_load,
    input  logic              id_redirect,
    output logic              stall_pc,
    output logic              stall_id,
    output logic              flush_id,
    output logic              bubble_ex,
    output logic              redirect,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_count
);

    localparam int EX_S = 0;
    localparam int MEM_S = 1;

`ifdef FORWARDING_EN
    // Only EX (load-use) and MEM (forward source) matter when forwarding.
    localparam int     MATCH_SLOTS = 2;
    localparam state_t STALL_STATE = S_LU_STALL;
`else
    localparam int     MATCH_SLOTS = NUM_SLOTS;
    localparam state_t STALL_STATE = S_RAW_WAIT;
`endif

    slot_t                  slot_d [NUM_SLOTS];
    slot_t                  slot_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]   slot_load;
    logic [MATCH_SLOTS-1:0] hit_rs1;
    logic [MATCH_SLOTS-1:0] hit_rs2;
    logic                   stall;
    logic                   ex_load;
    state_t                 state_reg;
    logic [CNT_W-1:0]       stall_count_reg;

    assign ex_load = id_valid & ~stall;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            if (gi == EX_S) begin : g_ex
                assign slot_d[gi]    = '{v: 1'b1, rd: id_rd, wr: id_reg_write, ld: id_load};
                assign slot_load[gi] = ex_load;
            end else begin : g_tail
                assign slot_d[gi]    = slot_q[gi-1];
                assign slot_load[gi] = 1'b1;
            end

            hazard_slot u_slot (
                .clk  (clk),
                .rst  (rst),
                .load (slot_load[gi]),
                .d    (slot_d[gi]),
                .q    (slot_q[gi])
            );
        end

        for (gi = 0; gi < MATCH_SLOTS; gi++) begin : g_hit
            assign hit_rs1[gi] = id_valid & slot_match(slot_q[gi], id_rs1, id_use_rs1);
            assign hit_rs2[gi] = id_valid & slot_match(slot_q[gi], id_rs2, id_use_rs2);
        end
    endgenerate

`ifdef FORWARDING_EN
    assign stall = slot_q[EX_S].ld & (hit_rs1[EX_S] | hit_rs2[EX_S]);
`else
    // Without a bypass, any in-flight producer (WB included) blocks the read.
    assign stall = (|hit_rs1) | (|hit_rs2);
`endif

    assign stall_pc  = stall;
    assign stall_id  = stall;
    assign bubble_ex = stall;
    assign redirect  = id_valid & id_redirect & ~stall;
    assign flush_id  = redirect;

`ifdef FORWARDING_EN
    logic [1:0] fwd_a_reg;
    logic [1:0] fwd_b_reg;

    // Selects travel with the instruction into EX; a bubble carries the register-file select.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_a_reg <= FWD_RF;
            fwd_b_reg <= FWD_RF;
        end else if (ex_load) begin
            fwd_a_reg <= fwd_pick(hit_rs1[EX_S], hit_rs1[MEM_S]);
            fwd_b_reg <= fwd_pick(hit_rs2[EX_S], hit_rs2[MEM_S]);
        end else begin
            fwd_a_reg <= FWD_RF;
            fwd_b_reg <= FWD_RF;
        end
    end

    assign fwd_a = fwd_a_reg;
    assign fwd_b = fwd_b_reg;
`else
    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_RUN;
        end else begin
            case (state_reg)
                S_RUN:      if (stall) state_reg <= STALL_STATE;
                S_LU_STALL: state_reg <= S_RUN;
                S_RAW_WAIT: if (!stall) state_reg <= S_RUN;
                default:    state_reg <= S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_count_reg <= '0;
        else if (stall && (stall_count_reg != {CNT_W{1'b1}}))
            stall_count_reg <= stall_count_reg + CNT_W'(1);
    end

    assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed table, hand sequences and a randomized model run.
module tb_hazard_ctrl;

    localparam int AW = 5;
    localparam int CW = 4;
    localparam int CNT_MAX = 15;
`ifdef FORWARDING_EN
    localparam bit FWD_MODE = 1'b1;
`else
    localparam bit FWD_MODE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    logic          id_use_rs1, id_use_rs2, id_reg_write, id_load, id_redirect;
    logic          stall_pc, stall_id, flush_id, bubble_ex, redirect;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_count;

    int vectors = 0;
    int miscompares = 0;

    hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_reg_write (id_reg_write),
        .id_load      (id_load),
        .id_redirect  (id_redirect),
        .stall_pc     (stall_pc),
        .stall_id     (stall_id),
        .flush_id     (flush_id),
        .bubble_ex    (bubble_ex),
        .redirect     (redirect),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v;
        int rs1, rs2, rd;
        bit u1, u2, wr, ld, br;
    } instr_t;

    typedef struct {
        instr_t i;
        bit     e_stall;
        bit     e_red;
        int     e_fa, e_fb, e_cnt;
    } vec_t;

    function automatic instr_t mk(bit v, int rs1, int rs2, int rd, bit u1, bit u2, bit wr, bit ld, bit br);
        instr_t x;
        x.v = v; x.rs1 = rs1; x.rs2 = rs2; x.rd = rd;
        x.u1 = u1; x.u2 = u2; x.wr = wr; x.ld = ld; x.br = br;
        return x;
    endfunction

    function automatic instr_t IDLE();                  return mk(0, 0, 0, 0, 0, 0, 0, 0, 0);     endfunction
    function automatic instr_t ALU(int rd, int a, int b); return mk(1, a, b, rd, 1, 1, 1, 0, 0);  endfunction
    function automatic instr_t LW(int rd, int a);       return mk(1, a, 0, rd, 1, 0, 1, 1, 0);    endfunction
    function automatic instr_t BR(int a, int b);        return mk(1, a, b, 0, 1, 1, 0, 0, 1);     endfunction

    function automatic vec_t row(instr_t i, bit s, bit r, int fa, int fb, int cnt);
        vec_t x;
        x.i = i; x.e_stall = s; x.e_red = r; x.e_fa = fa; x.e_fb = fb; x.e_cnt = cnt;
        return x;
    endfunction

    // Reference model: the last three instructions that entered EX, youngest first.
    instr_t m_pipe [3];
    int     m_fa, m_fb, m_cnt;

    function automatic bit produces(instr_t p, int r, bit use_r);
        return p.v && p.wr && (p.rd != 0) && use_r && (p.rd == r);
    endfunction

    function automatic bit m_stall(instr_t id);
        if (!id.v) return 1'b0;
        if (FWD_MODE)
            return m_pipe[0].ld && (produces(m_pipe[0], id.rs1, id.u1) || produces(m_pipe[0], id.rs2, id.u2));
        for (int k = 0; k < 3; k++)
            if (produces(m_pipe[k], id.rs1, id.u1) || produces(m_pipe[k], id.rs2, id.u2))
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_src(int r, bit use_r);
        if (!FWD_MODE) return 0;
        if (produces(m_pipe[0], r, use_r)) return 1;
        if (produces(m_pipe[1], r, use_r)) return 2;
        return 0;
    endfunction

    task automatic m_clock(instr_t id);
        bit s;
        instr_t nxt;
        s = m_stall(id);
        if (s && m_cnt < CNT_MAX) m_cnt++;
        if (!s && id.v) begin
            m_fa = m_src(id.rs1, id.u1);
            m_fb = m_src(id.rs2, id.u2);
            nxt  = id;
        end else begin
            m_fa = 0;
            m_fb = 0;
            nxt  = IDLE();
        end
        m_pipe[2] = m_pipe[1];
        m_pipe[1] = m_pipe[0];
        m_pipe[0] = nxt;
    endtask

    task automatic m_reset();
        for (int k = 0; k < 3; k++) m_pipe[k] = IDLE();
        m_fa = 0; m_fb = 0; m_cnt = 0;
    endtask

    task automatic drive(instr_t x);
        id_valid     = x.v;
        id_rs1       = AW'(x.rs1);
        id_rs2       = AW'(x.rs2);
        id_rd        = AW'(x.rd);
        id_use_rs1   = x.u1;
        id_use_rs2   = x.u2;
        id_reg_write = x.wr;
        id_load      = x.ld;
        id_redirect  = x.br;
    endtask

    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(string tag, bit es, bit er, int efa, int efb, int ecnt);
        chk({tag, " stall_pc"},    int'(stall_pc),    int'(es));
        chk({tag, " stall_id"},    int'(stall_id),    int'(es));
        chk({tag, " bubble_ex"},   int'(bubble_ex),   int'(es));
        chk({tag, " redirect"},    int'(redirect),    int'(er));
        chk({tag, " flush_id"},    int'(flush_id),    int'(er));
        chk({tag, " fwd_a"},       int'(fwd_a),       efa);
        chk({tag, " fwd_b"},       int'(fwd_b),       efb);
        chk({tag, " stall_count"}, int'(stall_count), ecnt);
        $display("%-12s v=%0b rs=%0d,%0d rd=%0d | stall=%0b red=%0b fwd=%0d/%0d cnt=%0d",
                 tag, id_valid, id_rs1, id_rs2, id_rd, stall_pc, redirect, fwd_a, fwd_b, stall_count);
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(instr_t x, string tag);
        bit es;
        drive(x);
        #1;
        es = m_stall(x);
        check_all(tag, es, x.v && x.br && !es, m_fa, m_fb, m_cnt);
        @(posedge clk);
        m_clock(x);
        @(negedge clk);
    endtask

    task automatic sync_reset();
        rst = 1'b0;
        m_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    vec_t   tbl [$];
    instr_t cur;
    instr_t pair [2];
    int     idx;
    bit     s;

    initial begin
        drive(IDLE());
        rst = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        #1 check_all("reset", 1'b0, 1'b0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;

`ifdef FORWARDING_EN
        tbl.push_back(row(ALU(3, 1, 2), 0, 0, 0, 0, 0));
        tbl.push_back(row(ALU(4, 3, 3), 0, 0, 0, 0, 0));  // sub x4,x3,x3
        tbl.push_back(row(ALU(0, 1, 2), 0, 0, 1, 1, 0));  // sub in EX forwards both from EX/MEM
        tbl.push_back(row(ALU(7, 0, 0), 0, 0, 0, 0, 0));
        tbl.push_back(row(LW(5, 1),     0, 0, 0, 0, 0));  // x0 destination never forwards
        tbl.push_back(row(ALU(6, 5, 1), 1, 0, 0, 0, 0));  // load-use stall
        tbl.push_back(row(ALU(6, 5, 1), 0, 0, 0, 0, 1));
        tbl.push_back(row(IDLE(),       0, 0, 2, 0, 1));  // add takes x5 from MEM/WB
        tbl.push_back(row(BR(7, 8),     0, 1, 0, 0, 1));
        tbl.push_back(row(IDLE(),       0, 0, 0, 0, 1));
        tbl.push_back(row(LW(5, 1),     0, 0, 0, 0, 1));
        tbl.push_back(row(BR(5, 0),     1, 0, 0, 0, 1));  // stall beats redirect
        tbl.push_back(row(BR(5, 0),     0, 1, 0, 0, 2));
        tbl.push_back(row(IDLE(),       0, 0, 2, 0, 2));
`else
        tbl.push_back(row(ALU(3, 1, 2), 0, 0, 0, 0, 0));
        tbl.push_back(row(ALU(4, 3, 0), 1, 0, 0, 0, 0));  // EX match
        tbl.push_back(row(ALU(4, 3, 0), 1, 0, 0, 0, 1));  // MEM match
        tbl.push_back(row(ALU(4, 3, 0), 1, 0, 0, 0, 2));  // WB match
        tbl.push_back(row(ALU(4, 3, 0), 0, 0, 0, 0, 3));
        tbl.push_back(row(IDLE(),       0, 0, 0, 0, 3));
        tbl.push_back(row(BR(7, 8),     0, 1, 0, 0, 3));
        tbl.push_back(row(IDLE(),       0, 0, 0, 0, 3));
        tbl.push_back(row(LW(5, 1),     0, 0, 0, 0, 3));
        tbl.push_back(row(BR(5, 0),     1, 0, 0, 0, 3));  // stall beats redirect
        tbl.push_back(row(BR(5, 0),     1, 0, 0, 0, 4));
        tbl.push_back(row(BR(5, 0),     1, 0, 0, 0, 5));
        tbl.push_back(row(BR(5, 0),     0, 1, 0, 0, 6));
        tbl.push_back(row(IDLE(),       0, 0, 0, 0, 6));
`endif

        foreach (tbl[n]) begin
            drive(tbl[n].i);
            #1 check_all($sformatf("tbl[%0d]", n), tbl[n].e_stall, tbl[n].e_red,
                         tbl[n].e_fa, tbl[n].e_fb, tbl[n].e_cnt);
            @(posedge clk);
            m_clock(tbl[n].i);
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a stall with stall_count at 5.
        sync_reset();
        pair[0] = LW(9, 1);
        pair[1] = ALU(10, 9, 9);
        idx = 0;
        cur = pair[0];
        for (int n = 0; n < 60 && !(m_cnt == 5 && m_stall(cur)); n++) begin
            s = m_stall(cur);
            step(cur, "pre_rst");
            if (!s) begin
                idx ^= 1;
                cur = pair[idx];
            end
        end
        drive(cur);
        #1;
        chk("midstall stall_pc", int'(stall_pc), 1);
        chk("midstall stall_count", int'(stall_count), 5);
        #2 rst = 1'b0;
        #1 check_all("async_rst", 1'b0, 1'b0, 0, 0, 0);
        m_reset();
        @(posedge clk);
        @(negedge clk);
        #1 check_all("in_rst", 1'b0, 1'b0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 8; n++) begin
            s = m_stall(cur);
            step(cur, "post_rst");
            if (!s) begin
                idx ^= 1;
                cur = pair[idx];
            end
        end

        // Saturation of the 4-bit counter.
        sync_reset();
        idx = 0;
        cur = pair[0];
        for (int n = 0; n < 90; n++) begin
            s = m_stall(cur);
            step(cur, "sat");
            if (!s) begin
                idx ^= 1;
                cur = pair[idx];
            end
        end
        #1 chk("saturated stall_count", int'(stall_count), CNT_MAX);

        // Randomized run against the model; a stalled instruction is held in ID.
        sync_reset();
        @(negedge clk);
        cur = IDLE();
        for (int n = 0; n < 300; n++) begin
            if (!m_stall(cur)) begin
                cur.v   = ($urandom_range(0, 7) != 0);
                cur.rs1 = $urandom_range(0, 3);
                cur.rs2 = $urandom_range(0, 3);
                cur.rd  = $urandom_range(0, 3);
                cur.u1  = $urandom_range(0, 3) != 0;
                cur.u2  = $urandom_range(0, 1);
                cur.wr  = $urandom_range(0, 3) != 0;
                cur.ld  = $urandom_range(0, 2) == 0;
                cur.br  = $urandom_range(0, 4) == 0;
            end
            step(cur, $sformatf("rnd[%0d]", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
